// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and command layout for the ALU issue block.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  localparam int CMD_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] ctrl;
    logic [7:0] data0;
    logic [7:0] data1;
  } cmd_t;

  // Returns {err, data}; error substitutes take priority over the ALU's answer.
  function automatic logic [8:0] resolve_result(input cmd_t cmd, input logic [7:0] alu_result);
    logic [8:0] res;
    if (cmd.ctrl > OP_MOD) begin
      res = {1'b1, 8'h00};
    end else if ((cmd.ctrl == OP_DIV || cmd.ctrl == OP_MOD) && cmd.data1 == 8'h00) begin
      res = {1'b1, 8'hFF};
    end else begin
      res = {1'b0, alu_result};
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-two depth, synchronous reset of pointers and occupancy.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; only the pointers and count
  // define which entries are live, so resetting the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Queues ALU commands, issues one per two cycles to an external combinational ALU,
// and holds each result (or an error substitute) until the consumer accepts it.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [2:0]               cmd_ctrl_i,
  input  logic [7:0]               cmd_data0_i,
  input  logic [7:0]               cmd_data1_i,
  output logic [2:0]               alu_ctrl_o,
  output logic [7:0]               alu_data0_o,
  output logic [7:0]               alu_data1_o,
  input  logic [7:0]               alu_result_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [7:0]               res_data_o,
  output logic                     res_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  state_t state;
  cmd_t   in_cmd;
  cmd_t   head;
  cmd_t   issue_cmd;
  logic   fifo_full;
  logic   fifo_empty;

  assign in_cmd      = '{ctrl: cmd_ctrl_i, data0: cmd_data0_i, data1: cmd_data1_i};
  assign cmd_ready_o = !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (cmd_valid_i && cmd_ready_o),
    .wdata (in_cmd),
    .pop   (state == ST_ISSUE),
    .rdata (head),
    .count (count_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign alu_ctrl_o  = issue_cmd.ctrl;
  assign alu_data0_o = issue_cmd.data0;
  assign alu_data1_o = issue_cmd.data1;

  // issue_cmd is loaded on entry to ISSUE and cleared on exit, so the ALU
  // operands are registered and read zero in IDLE and HOLD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      issue_cmd   <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state     <= ST_ISSUE;
            issue_cmd <= head;
          end
        end
        ST_ISSUE: begin
          state                   <= ST_HOLD;
          issue_cmd               <= '0;
          res_valid_o             <= 1'b1;
          {res_err_o, res_data_o} <= resolve_result(issue_cmd, alu_result_i);
        end
        ST_HOLD: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            if (!fifo_empty) begin
              state     <= ST_ISSUE;
              issue_cmd <= head;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          issue_cmd <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: stimulus queues expected results, a negedge
// monitor pops and compares on every accepted result.
module tb_alu_issue;
  import alu_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [2:0] cmd_ctrl_i;
  logic [7:0] cmd_data0_i;
  logic [7:0] cmd_data1_i;
  logic [2:0] alu_ctrl_o;
  logic [7:0] alu_data0_o;
  logic [7:0] alu_data1_o;
  logic [7:0] alu_result_i;
  logic       res_valid_o;
  logic       res_ready_i;
  logic [7:0] res_data_o;
  logic       res_err_o;
  logic [2:0] count_o;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  alu_issue #(.DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_ctrl_i   (cmd_ctrl_i),
    .cmd_data0_i  (cmd_data0_i),
    .cmd_data1_i  (cmd_data1_i),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_data0_o  (alu_data0_o),
    .alu_data1_o  (alu_data1_o),
    .alu_result_i (alu_result_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_err_o    (res_err_o),
    .count_o      (count_o)
  );

  // Downstream ALU; junk values on divide-by-zero and illegal opcodes must never surface.
  always_comb begin
    alu_result_i = 8'hA5;
    case (alu_ctrl_o)
      OP_ADD: alu_result_i = alu_data0_o + alu_data1_o;
      OP_SUB: alu_result_i = alu_data0_o - alu_data1_o;
      OP_MUL: alu_result_i = alu_data0_o * alu_data1_o;
      OP_DIV: alu_result_i = (alu_data1_o != 0) ? alu_data0_o / alu_data1_o : 8'h5A;
      OP_MOD: alu_result_i = (alu_data1_o != 0) ? alu_data0_o % alu_data1_o : 8'h5A;
      default: alu_result_i = 8'hA5;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && res_valid_o && res_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got data %0h err %0b with nothing expected", res_data_o, res_err_o);
      end else begin
        mon_exp = sb.pop_front();
        check("result_data", {24'h0, res_data_o}, {24'h0, mon_exp.data});
        check("result_err", {31'h0, res_err_o}, {31'h0, mon_exp.err});
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_data, input logic exp_err);
    int waited = 0;
    cmd_valid_i = 1'b1;
    cmd_ctrl_i  = op;
    cmd_data0_i = a;
    cmd_data1_i = b;
    @(negedge clk_i);
    while (!cmd_ready_o && waited < 50) begin
      waited++;
      @(negedge clk_i);
    end
    if (!cmd_ready_o) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: cmd_ready_o stayed 0 for op %0d", op);
    end else begin
      sb.push_back('{err: exp_err, data: exp_data});
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_ctrl_i  = '0;
    cmd_data0_i = '0;
    cmd_data1_i = '0;
    res_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count", {29'h0, count_o}, 0);
    check("rst_res_valid", {31'h0, res_valid_o}, 0);
    check("rst_res_data", {24'h0, res_data_o}, 0);
    check("rst_res_err", {31'h0, res_err_o}, 0);
    check("rst_alu", {13'h0, alu_ctrl_o, alu_data0_o, alu_data1_o}, 0);
    check("rst_cmd_ready", {31'h0, cmd_ready_o}, 1);
    rst_i = 1'b0;

    // Single add: latency of two edges from the push.
    res_ready_i = 1'b1;
    send(OP_ADD, 8'd10, 8'd1, 8'd11, 1'b0);
    check("lat_t0_valid", {31'h0, res_valid_o}, 0);
    check("lat_t0_count", {29'h0, count_o}, 1);
    @(posedge clk_i); #1;
    check("lat_t1_valid", {31'h0, res_valid_o}, 0);
    check("issue_alu", {13'h0, alu_ctrl_o, alu_data0_o, alu_data1_o}, {13'h0, OP_ADD, 8'd10, 8'd1});
    @(posedge clk_i); #1;
    check("lat_t2_valid", {31'h0, res_valid_o}, 1);
    check("lat_t2_data", {24'h0, res_data_o}, 11);
    check("hold_alu_zero", {13'h0, alu_ctrl_o, alu_data0_o, alu_data1_o}, 0);
    @(posedge clk_i); #1;
    check("after_accept_valid", {31'h0, res_valid_o}, 0);

    // Fill and order with the consumer stalled.
    res_ready_i = 1'b0;
    send(OP_SUB, 8'd20, 8'd10, 8'd10, 1'b0);
    send(OP_MUL, 8'd8, 8'd8, 8'd64, 1'b0);
    send(OP_DIV, 8'd12, 8'd2, 8'd6, 1'b0);
    send(OP_MOD, 8'd15, 8'd3, 8'd0, 1'b0);
    send(OP_ADD, 8'd200, 8'd100, 8'd44, 1'b0);
    check("full_count", {29'h0, count_o}, 4);
    check("full_ready", {31'h0, cmd_ready_o}, 0);

    // Backpressure while full; the offered command must not be taken.
    cmd_valid_i = 1'b1;
    cmd_ctrl_i  = OP_ADD;
    cmd_data0_i = 8'd1;
    cmd_data1_i = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("bp_valid", {31'h0, res_valid_o}, 1);
      check("bp_data", {24'h0, res_data_o}, 10);
      check("bp_err", {31'h0, res_err_o}, 0);
      check("bp_alu_zero", {13'h0, alu_ctrl_o, alu_data0_o, alu_data1_o}, 0);
      check("bp_count", {29'h0, count_o}, 4);
    end
    cmd_valid_i = 1'b0;
    res_ready_i = 1'b1;
    drain();
    check("drained_count", {29'h0, count_o}, 0);

    // Error substitutes.
    send(OP_DIV, 8'd7, 8'd0, 8'hFF, 1'b1);
    send(OP_MOD, 8'd7, 8'd0, 8'hFF, 1'b1);
    send(3'b110, 8'd5, 8'd5, 8'h00, 1'b1);
    send(3'b111, 8'd9, 8'd3, 8'h00, 1'b1);
    send(OP_SUB, 8'd5, 8'd7, 8'hFE, 1'b0);
    drain();

    // Reset with three queued and one held; a push alongside reset is dropped.
    res_ready_i = 1'b0;
    send(OP_ADD, 8'd1, 8'd2, 8'd3, 1'b0);
    send(OP_ADD, 8'd3, 8'd4, 8'd7, 1'b0);
    send(OP_ADD, 8'd5, 8'd6, 8'd11, 1'b0);
    send(OP_ADD, 8'd7, 8'd8, 8'd15, 1'b0);
    check("pre_rst_count", {29'h0, count_o}, 3);
    check("pre_rst_valid", {31'h0, res_valid_o}, 1);
    rst_i       = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_ctrl_i  = OP_MUL;
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    cmd_valid_i = 1'b0;
    sb.delete();
    check("mid_rst_count", {29'h0, count_o}, 0);
    check("mid_rst_valid", {31'h0, res_valid_o}, 0);
    check("mid_rst_data", {24'h0, res_data_o}, 0);
    check("mid_rst_ready", {31'h0, cmd_ready_o}, 1);
    res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      check("no_stale_valid", {31'h0, res_valid_o}, 0);
    end
    send(OP_MUL, 8'd16, 8'd17, 8'h10, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
